// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing and framebuffer address
// generator. The address is produced combinationally from the raster
// counters. Sync, blank, strobes and row pass through a DELAY-deep register
// pipe, so they trail the address by DELAY clocks. That lag covers the
// framebuffer fetch latency.
module vga_timing_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter bit HPOL    = 1'b0,
  parameter int V_VIS   = 400,
  parameter int V_FP    = 12,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 35,
  parameter bit VPOL    = 1'b1,
  parameter int X_SHIFT = 1,
  parameter int Y_SHIFT = 1,
  parameter int ADDR_W  = 16,
  parameter int DELAY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [ADDR_W-1:0] addr,
  output logic              line_start,
  output logic              frame_start,
  output logic [9:0]        row
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Bad geometry is caught at elaboration rather than producing a broken raster.
  if (H_TOT > 1024) begin : g_bad_htot
    $error("vga_timing_gen: H_TOT must be at most 1024");
  end
  if (V_TOT > 1024) begin : g_bad_vtot
    $error("vga_timing_gen: V_TOT must be at most 1024");
  end
  if ((H_VIS % (1 << X_SHIFT)) != 0) begin : g_bad_xshift
    $error("vga_timing_gen: H_VIS must be divisible by 2**X_SHIFT");
  end
  if ((DELAY < 1) || (DELAY > 4)) begin : g_bad_delay
    $error("vga_timing_gen: DELAY must be in 1..4");
  end

  localparam logic [9:0]  X_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOT - 1);
  // Decode bounds are 11 bits wide because a porch edge can sit at 1024.
  localparam logic [10:0] X_VISEND = 11'(H_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] Y_VISEND = 11'(V_VIS);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  localparam int              LC_W    = (Y_SHIFT > 0) ? Y_SHIFT : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'((1 << Y_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_VIS >> X_SHIFT);

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic [9:0] row;
  } stage_t;

  localparam stage_t STAGE_RST = '{
    hsync: ~HPOL, vsync: ~VPOL, blank: 1'b1,
    line_start: 1'b0, frame_start: 1'b0, row: 10'd0
  };

  logic [9:0]        x;
  logic [9:0]        y;
  logic [LC_W-1:0]   lc;
  logic [ADDR_W-1:0] row_base;
  logic              x_wrap;
  logic              y_wrap;
  logic              y_vis;
  stage_t            stage0;
  stage_t            pipe [DELAY];

  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);
  assign y_vis  = ({1'b0, y} < Y_VISEND);

  // Raster counters: x every clock, y on each x wrap.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x_wrap) begin
      x <= '0;
      y <= y_wrap ? '0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  // Row base advances by one stride every 2**Y_SHIFT visible lines and is
  // cleared at the end of the frame. The clear wins over the advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc       <= '0;
      row_base <= '0;
    end else if (x_wrap) begin
      if (y_wrap) begin
        lc       <= '0;
        row_base <= '0;
      end else if (y_vis) begin
        if (lc == LC_LAST) begin
          lc       <= '0;
          row_base <= row_base + STRIDE;
        end else begin
          lc <= lc + 1'b1;
        end
      end
    end
  end

  // The address is not pipelined. It leads the sync/blank pipe by DELAY clocks.
  assign addr = row_base + ADDR_W'(x >> X_SHIFT);

  // Stage-0 decode of sync, blank, strobes and row from the current counters.
  // NOTE: a default is assigned first so no path through this block can
  // leave a field unassigned and infer a latch.
  always_comb begin
    stage0             = STAGE_RST;
    stage0.hsync       = (({1'b0, x} >= HS_START) && ({1'b0, x} < HS_END)) ? HPOL : ~HPOL;
    stage0.vsync       = (({1'b0, y} >= VS_START) && ({1'b0, y} < VS_END)) ? VPOL : ~VPOL;
    stage0.blank       = ({1'b0, x} >= X_VISEND) || !y_vis;
    stage0.line_start  = (x == 10'd0);
    stage0.frame_start = (x == 10'd0) && (y == 10'd0);
    stage0.row         = y;
  end

  // DELAY-deep register pipe. Every output is taken straight from a flop.
  // NOTE: this small pipe is reset so the outputs are idle (blanked, sync
  // inactive) from the first clock after release. Large storage arrays would
  // normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= STAGE_RST;
    end else begin
      pipe[0] <= stage0;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync       = pipe[DELAY-1].hsync;
  assign vsync       = pipe[DELAY-1].vsync;
  assign blank       = pipe[DELAY-1].blank;
  assign line_start  = pipe[DELAY-1].line_start;
  assign frame_start = pipe[DELAY-1].frame_start;
  assign row         = pipe[DELAY-1].row;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three configurations share one clock and
// reset: the default 640x400 timing, a small ADDR_W=8 raster with no
// replication, and a small DELAY=3 raster with 4x replication and inverted
// sync polarities. Every cycle is compared against a closed-form model of
// the raster. A table of hand-derived points, frame-count sequences and
// random asynchronous resets cover the corner cases.
module tb_vga_timing_gen;

  typedef struct {
    int h_vis, h_fp, h_sync, h_bp;
    bit hpol;
    int v_vis, v_fp, v_sync, v_bp;
    bit vpol;
    int xs, ys, aw, delay;
  } cfg_t;

  typedef enum {F_BLANK, F_HSYNC, F_VSYNC, F_LS, F_FS, F_ROW, F_ADDR} field_e;

  typedef struct {
    int     inst;
    int     t;
    field_e field;
    int     val;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   t     = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   check_en = 1'b0;
  cfg_t cfgs [3];
  vec_t vecs [$];

  logic hsync_a, vsync_a, blank_a, ls_a, fs_a;
  logic [9:0]  row_a;
  logic [15:0] addr_a;
  logic hsync_b, vsync_b, blank_b, ls_b, fs_b;
  logic [9:0]  row_b;
  logic [7:0]  addr_b;
  logic hsync_c, vsync_c, blank_c, ls_c, fs_c;
  logic [9:0]  row_c;
  logic [15:0] addr_c;

  vga_timing_gen #(
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48), .HPOL(1'b0),
    .V_VIS(400), .V_FP(12), .V_SYNC(2), .V_BP(35), .VPOL(1'b1),
    .X_SHIFT(1), .Y_SHIFT(1), .ADDR_W(16), .DELAY(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .hsync(hsync_a), .vsync(vsync_a),
    .blank(blank_a), .addr(addr_a), .line_start(ls_a),
    .frame_start(fs_a), .row(row_a)
  );

  vga_timing_gen #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .HPOL(1'b0),
    .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .VPOL(1'b1),
    .X_SHIFT(0), .Y_SHIFT(0), .ADDR_W(8), .DELAY(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hsync(hsync_b), .vsync(vsync_b),
    .blank(blank_b), .addr(addr_b), .line_start(ls_b),
    .frame_start(fs_b), .row(row_b)
  );

  vga_timing_gen #(
    .H_VIS(32), .H_FP(2), .H_SYNC(4), .H_BP(2), .HPOL(1'b1),
    .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .VPOL(1'b0),
    .X_SHIFT(2), .Y_SHIFT(2), .ADDR_W(16), .DELAY(3)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .hsync(hsync_c), .vsync(vsync_c),
    .blank(blank_c), .addr(addr_c), .line_start(ls_c),
    .frame_start(fs_c), .row(row_c)
  );

  // Posedges at 5, 15, 25 ns; samples are taken on the negedge.
  always #5 clk = ~clk;

  // Cycles since reset release. This equals the raster position x + y*H_TOT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  // Packed layout: {hsync, vsync, blank, line_start, frame_start, row[9:0], addr[15:0]}.
  function automatic logic [30:0] pack(logic hs, logic vs, logic bl, logic ls,
                                       logic fs, logic [9:0] rw, logic [15:0] ad);
    return {hs, vs, bl, ls, fs, rw, ad};
  endfunction

  // Closed-form reference: position from the cycle count, row base from the
  // number of visible lines completed, and outputs that trail by DELAY.
  function automatic logic [30:0] model(cfg_t c, int tc);
    int htot, vtot, x, y, xd, yd, done;
    longint rb, a;
    logic hs, vs, bl, ls, fs;
    logic [9:0] rw;
    htot = c.h_vis + c.h_fp + c.h_sync + c.h_bp;
    vtot = c.v_vis + c.v_fp + c.v_sync + c.v_bp;
    x    = tc % htot;
    y    = (tc / htot) % vtot;
    done = (y < c.v_vis) ? y : c.v_vis;
    rb   = longint'(done >> c.ys) * longint'(c.h_vis >> c.xs);
    a    = (rb + longint'(x >> c.xs)) % (longint'(1) << c.aw);
    if (tc < c.delay) begin
      hs = !c.hpol; vs = !c.vpol; bl = 1'b1; ls = 1'b0; fs = 1'b0; rw = 10'd0;
    end else begin
      xd = (tc - c.delay) % htot;
      yd = ((tc - c.delay) / htot) % vtot;
      hs = (xd >= c.h_vis + c.h_fp && xd < c.h_vis + c.h_fp + c.h_sync) ? c.hpol : !c.hpol;
      vs = (yd >= c.v_vis + c.v_fp && yd < c.v_vis + c.v_fp + c.v_sync) ? c.vpol : !c.vpol;
      bl = (xd >= c.h_vis) || (yd >= c.v_vis);
      ls = (xd == 0);
      fs = (xd == 0) && (yd == 0);
      rw = 10'(yd);
    end
    return pack(hs, vs, bl, ls, fs, rw, 16'(a));
  endfunction

  function automatic logic [30:0] act_of(int inst);
    case (inst)
      0:       return pack(hsync_a, vsync_a, blank_a, ls_a, fs_a, row_a, addr_a);
      1:       return pack(hsync_b, vsync_b, blank_b, ls_b, fs_b, row_b, {8'h00, addr_b});
      default: return pack(hsync_c, vsync_c, blank_c, ls_c, fs_c, row_c, addr_c);
    endcase
  endfunction

  function automatic int field_of(logic [30:0] v, field_e f);
    case (f)
      F_HSYNC: return int'(v[30]);
      F_VSYNC: return int'(v[29]);
      F_BLANK: return int'(v[28]);
      F_LS:    return int'(v[27]);
      F_FS:    return int'(v[26]);
      F_ROW:   return int'(v[25:16]);
      default: return int'(v[15:0]);
    endcase
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(int inst, int tc, field_e f, int val);
    vec_t v;
    v.inst = inst; v.t = tc; v.field = f; v.val = val;
    vecs.push_back(v);
  endtask

  // Compare all three instances against the model at the current time.
  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_dut%0d_t%0d", tag, i, t), longint'(act_of(i)),
            longint'(model(cfgs[i], t)));
  endtask

  // Cycle-by-cycle model comparison.
  always @(negedge clk) begin
    if (check_en) check_all("cycle");
  end

  // Release on the low phase. Return 1 ns later, while t is still 0.
  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_t(int target);
    int guard = 0;
    while (t < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (t != target) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_t: reached t=%0d, expected t=%0d", t, target);
    end
  endtask

  initial begin
    int cnt_fs, cnt_ls, cnt_vs, n, offs, hold;

    cfgs[0] = '{640, 16, 96, 48, 1'b0, 400, 12, 2, 35, 1'b1, 1, 1, 16, 1};
    cfgs[1] = '{64, 4, 8, 4, 1'b0, 8, 2, 2, 2, 1'b1, 0, 0, 8, 1};
    cfgs[2] = '{32, 2, 4, 2, 1'b1, 12, 1, 2, 1, 1'b0, 2, 2, 16, 3};

    // Hand-derived points, in ascending t. Instances: 0=defaults, 1=ADDR_W 8, 2=DELAY 3.
    add(0, 0, F_BLANK, 1);    add(0, 0, F_ADDR, 0);     add(0, 0, F_FS, 0);
    add(0, 1, F_BLANK, 0);    add(0, 1, F_FS, 1);       add(0, 1, F_LS, 1);
    add(0, 2, F_ADDR, 1);     add(2, 2, F_FS, 0);       add(2, 2, F_BLANK, 1);
    add(2, 3, F_FS, 1);       add(2, 3, F_BLANK, 0);
    add(2, 36, F_HSYNC, 0);   add(2, 37, F_HSYNC, 1);   add(2, 43, F_ROW, 1);
    add(2, 159, F_ADDR, 9);   add(2, 160, F_ADDR, 8);
    add(1, 303, F_ADDR, 255); add(1, 320, F_ADDR, 0);
    add(0, 639, F_ADDR, 319); add(0, 640, F_BLANK, 0);  add(0, 641, F_BLANK, 1);
    add(0, 656, F_HSYNC, 1);  add(0, 657, F_HSYNC, 0);
    add(0, 752, F_HSYNC, 0);  add(0, 753, F_HSYNC, 1);
    add(0, 800, F_ADDR, 0);   add(0, 801, F_ROW, 1);    add(0, 801, F_LS, 1);
    add(0, 1439, F_ADDR, 319); add(0, 1600, F_ADDR, 320); add(0, 1601, F_ROW, 2);

    // Power-on reset: outputs hold their idle values.
    repeat (3) @(posedge clk);
    #1 check_all("por");
    check_en = 1'b1;
    release_reset();

    // Walk the table from a fresh release.
    foreach (vecs[i]) begin
      wait_t(vecs[i].t);
      check($sformatf("vec%0d_dut%0d_t%0d", i, vecs[i].inst, vecs[i].t),
            field_of(act_of(vecs[i].inst), vecs[i].field), vecs[i].val);
    end

    // Two full frames of the small raster: pulse and sync counts.
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    cnt_fs = 0; cnt_ls = 0; cnt_vs = 0;
    for (int i = 0; i < 2240; i++) begin
      @(negedge clk);
      cnt_fs += int'(fs_b);
      cnt_ls += int'(ls_b);
      cnt_vs += int'(vsync_b);
    end
    check("frame_start_count", cnt_fs, 2);
    check("line_start_count", cnt_ls, 28);
    check("vsync_active_cycles", cnt_vs, 320);

    // Mid-frame reset, asserted between clock edges.
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    wait_t(430);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_blank_a", blank_a, 1);
    check("async_hsync_a", hsync_a, 1);
    check("async_vsync_c", vsync_c, 1);
    check("async_addr_b", addr_b, 0);
    check("async_row_b", row_b, 0);
    repeat (5) @(posedge clk);
    release_reset();
    check("rel_addr_a", addr_a, 0);
    check("rel_addr_b", addr_b, 0);
    @(negedge clk);
    check("rel_fs_a_t1", fs_a, 1);
    check("rel_fs_b_t1", fs_b, 1);
    check("rel_fs_c_t1", fs_c, 0);
    repeat (2) @(negedge clk);
    check("rel_fs_c_t3", fs_c, 1);

    // Random run lengths with random async resets. The model checks every cycle.
    for (int it = 0; it < 8; it++) begin
      n    = int'($urandom_range(50, 2500));
      offs = int'($urandom_range(1, 4));
      hold = int'($urandom_range(1, 5));
      repeat (n) @(negedge clk);
      @(posedge clk);
      #(offs) rst_n = 1'b0;
      #1 check_all($sformatf("rnd%0d_async", it));
      repeat (hold) @(posedge clk);
      release_reset();
    end
    repeat (50) @(negedge clk);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
